// File: rtl/uart_alu_interface_pkg.sv
// Purpose: shared opcodes, FSM state encoding and width defaults for the UART calculator path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DBIT_DEF/NB_OP_DEF defaults, OP_* opcodes (NB_OP_DEF wide), state_t (3-bit).
package uart_alu_interface_pkg;

    localparam int DBIT_DEF  = 8;
    localparam int NB_OP_DEF = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Purpose: bundles the receiver/transmitter handshake and result signals of the calculator block.
// Latency: n/a (wiring only).
// Backpressure: none on rx (pulses are dropped when busy); tx side waits for i_tx_done.
// Ports: i_rx_done/i_rx_data, i_tx_done into the block; o_tx_start/o_tx_data, o_result, o_busy out.
interface uart_alu_if
    import uart_alu_interface_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
);
    logic            i_rx_done;
    logic [DBIT-1:0] i_rx_data;
    logic            i_tx_done;
    logic            o_tx_start;
    logic [DBIT-1:0] o_tx_data;
    logic [DBIT-1:0] o_result;
    logic            o_busy;

    // Calculator block side.
    modport slave (
        input  i_rx_done, i_rx_data, i_tx_done,
        output o_tx_start, o_tx_data, o_result, o_busy
    );

    // UART receiver/transmitter side.
    modport master (
        output i_rx_done, i_rx_data, i_tx_done,
        input  o_tx_start, o_tx_data, o_result, o_busy
    );

endinterface

// File: rtl/uart_alu_interface_alu.sv
// Purpose: combinational ALU (add/sub/logic/shifts) on two DBIT operands.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: i_a, i_b operands; i_op opcode (NB_OP bits); o_result DBIT result, 0 for unknown opcodes.
module alu
    import uart_alu_interface_pkg::*;
#(
    parameter int DBIT  = DBIT_DEF,
    parameter int NB_OP = NB_OP_DEF
) (
    input  logic [DBIT-1:0]  i_a,
    input  logic [DBIT-1:0]  i_b,
    input  logic [NB_OP-1:0] i_op,
    output logic [DBIT-1:0]  o_result
);

    logic                   w_shift_ovf;
    logic signed [DBIT-1:0] w_sra;

    always_comb begin
        w_shift_ovf = 1'b0;
        w_sra       = '0;
        o_result    = '0;

        w_shift_ovf = (32'(i_b) >= 32'(DBIT));
        // Kept in its own signed variable so the arithmetic shift is not
        // turned into a logical one by an unsigned surrounding expression.
        w_sra       = $signed(i_a) >>> i_b;

        case (i_op)
            NB_OP'(OP_ADD): o_result = i_a + i_b;
            NB_OP'(OP_SUB): o_result = i_a - i_b;
            NB_OP'(OP_AND): o_result = i_a & i_b;
            NB_OP'(OP_OR):  o_result = i_a | i_b;
            NB_OP'(OP_XOR): o_result = i_a ^ i_b;
            NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
            NB_OP'(OP_SRA): o_result = w_shift_ovf ? {DBIT{i_a[DBIT-1]}} : w_sra;
            NB_OP'(OP_SRL): o_result = w_shift_ovf ? '0 : (i_a >> i_b);
            default:        o_result = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Purpose: collects A, B, opcode bytes from the UART receiver, computes the ALU result, sends it to the transmitter.
// Latency: opcode rx_done in cycle N -> o_result valid and o_tx_start pulse in cycle N+2.
// Backpressure: rx bytes arriving in COMPUTE/SEND/WAIT_TX are dropped; returns to WAIT_A only on i_tx_done.
// Ports: i_clock, i_reset (sync, active-high); bus (uart_alu_if.slave) carries rx/tx handshake, o_result, o_busy.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int DBIT  = DBIT_DEF,
    parameter int NB_OP = NB_OP_DEF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    uart_alu_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [DBIT-1:0]  r_a;
    logic [DBIT-1:0]  r_b;
    logic [NB_OP-1:0] r_op;
    logic [DBIT-1:0]  r_result;
    logic [DBIT-1:0]  w_alu_result;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_load_op;
    logic             w_load_result;

    alu #(
        .DBIT  (DBIT),
        .NB_OP (NB_OP)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result)
    );

    always_comb begin
        w_state_next  = r_state;
        w_load_a      = 1'b0;
        w_load_b      = 1'b0;
        w_load_op     = 1'b0;
        w_load_result = 1'b0;

        case (r_state)
            ST_WAIT_A: begin
                if (bus.i_rx_done) begin
                    w_load_a     = 1'b1;
                    w_state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_done) begin
                    w_load_b     = 1'b1;
                    w_state_next = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    w_load_op    = 1'b1;
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                w_load_result = 1'b1;
                w_state_next  = ST_SEND;
            end
            ST_SEND: begin
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // Any rx byte in this state is simply not loaded.
                if (bus.i_tx_done) begin
                    w_state_next = ST_WAIT_A;
                end
            end
            default: begin
                w_state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_WAIT_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_a) begin
                r_a <= bus.i_rx_data;
            end
            if (w_load_b) begin
                r_b <= bus.i_rx_data;
            end
            if (w_load_op) begin
                r_op <= bus.i_rx_data[NB_OP-1:0];
            end
            if (w_load_result) begin
                r_result <= w_alu_result;
            end
        end
    end

    // One register feeds both outputs: it only changes in COMPUTE, so it is
    // stable from the start pulse through i_tx_done and until the next compute.
    assign bus.o_tx_data  = r_result;
    assign bus.o_result   = r_result;
    assign bus.o_tx_start = (r_state == ST_SEND);
    assign bus.o_busy     = (r_state == ST_COMPUTE) || (r_state == ST_SEND) ||
                            (r_state == ST_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Purpose: directed self-checking bench for uart_alu_interface.
// Latency: expects o_tx_start/o_result two cycles after the opcode rx_done.
// Backpressure: exercises dropped rx bytes while busy and coincident rx/tx done.
module tb_uart_alu_interface;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   tx_count;

    uart_alu_if #(.DBIT(8)) bus ();

    uart_alu_interface #(
        .DBIT  (8),
        .NB_OP (6)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs only depend on state, so sampling at negedge is race-free.
    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) tx_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Drives three back-to-back rx pulses; returns at the negedge where the DUT sits in COMPUTE.
    task automatic feed3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        @(negedge clk); bus.i_rx_done = 1'b1; bus.i_rx_data = a;
        @(negedge clk); bus.i_rx_data = b;
        @(negedge clk); bus.i_rx_data = op;
        @(negedge clk); bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00;
    endtask

    task automatic do_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp, input string name);
        int start0;
        start0 = tx_count;
        feed3(a, b, op);
        checks++;
        if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s compute: tx_start=%b busy=%b, want 0/1", name, bus.o_tx_start, bus.o_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== exp || bus.o_result !== exp) begin
            errors++;
            $display("FAIL %s send: tx_start=%b tx_data=%h result=%h, want 1/%h/%h",
                     name, bus.o_tx_start, bus.o_tx_data, bus.o_result, exp, exp);
        end
        @(negedge clk);
        checks++;
        if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_tx_data !== exp) begin
            errors++;
            $display("FAIL %s wait_tx: tx_start=%b busy=%b tx_data=%h, want 0/1/%h",
                     name, bus.o_tx_start, bus.o_busy, bus.o_tx_data, exp);
        end
        bus.i_tx_done = 1'b1;
        @(negedge clk); bus.i_tx_done = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_result !== exp || (tx_count - start0) != 1) begin
            errors++;
            $display("FAIL %s done: busy=%b result=%h pulses=%0d, want 0/%h/1",
                     name, bus.o_busy, bus.o_result, tx_count - start0, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h55;
        bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 ||
            bus.o_tx_data !== 8'h00 || bus.o_result !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: start=%b busy=%b tx_data=%h result=%h, want 0/0/00/00",
                     bus.o_tx_start, bus.o_busy, bus.o_tx_data, bus.o_result);
        end
        rst = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        do_seq(8'h05, 8'h03, 8'h20, 8'h08, "add");
        do_seq(8'h03, 8'h05, 8'h22, 8'hFE, "sub_wrap");
        do_seq(8'hFF, 8'h01, 8'h20, 8'h00, "add_wrap");
        do_seq(8'hAA, 8'h0F, 8'h24, 8'h0A, "and");
        do_seq(8'hA0, 8'h05, 8'h25, 8'hA5, "or");
        do_seq(8'hFF, 8'h0F, 8'h26, 8'hF0, "xor");
        do_seq(8'h80, 8'h02, 8'h03, 8'hE0, "sra");
        do_seq(8'h80, 8'h02, 8'h02, 8'h20, "srl");
        do_seq(8'h80, 8'h09, 8'h03, 8'hFF, "sra_ovf");
        do_seq(8'hFF, 8'h08, 8'h02, 8'h00, "srl_ovf");
        do_seq(8'hAA, 8'h55, 8'h3F, 8'h00, "unknown_op");
        do_seq(8'hF0, 8'h0F, 8'hE7, 8'h00, "nor_upper_bits");
    endtask

    task automatic test_abort();
        int start0;
        // Partial sequence aborted in WAIT_B.
        @(negedge clk); bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h11;
        @(negedge clk); bus.i_rx_done = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        do_seq(8'h02, 8'h03, 8'h20, 8'h05, "after_abort");
        // Abort in WAIT_TX clears outputs; no further start pulse.
        feed3(8'h05, 8'h03, 8'h20);
        @(negedge clk);
        @(negedge clk);
        start0 = tx_count;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 || bus.o_result !== 8'h00 ||
            tx_count != start0) begin
            errors++;
            $display("FAIL abort_wait_tx: busy=%b start=%b result=%h extra_pulses=%0d, want 0/0/00/0",
                     bus.o_busy, bus.o_tx_start, bus.o_result, tx_count - start0);
        end
    endtask

    task automatic test_drop();
        feed3(8'h05, 8'h03, 8'h20);
        bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h77;   // lands in COMPUTE
        @(negedge clk); bus.i_rx_done = 1'b0;
        checks++;
        if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h08) begin
            errors++;
            $display("FAIL drop_compute: start=%b tx_data=%h, want 1/08", bus.o_tx_start, bus.o_tx_data);
        end
        @(negedge clk); bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h77;   // lands in WAIT_TX
        @(negedge clk); bus.i_rx_done = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_tx_data !== 8'h08) begin
            errors++;
            $display("FAIL drop_wait_tx: busy=%b tx_data=%h, want 1/08", bus.o_busy, bus.o_tx_data);
        end
        bus.i_tx_done = 1'b1;
        @(negedge clk); bus.i_tx_done = 1'b0;
        // Second run: rx and tx done coincide in WAIT_TX.
        feed3(8'h05, 8'h03, 8'h20);
        @(negedge clk);
        @(negedge clk);
        bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h77; bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_coincident: busy=%b, want 0", bus.o_busy);
        end
        // Stray tx_done in WAIT_A is ignored.
        bus.i_tx_done = 1'b1;
        @(negedge clk); bus.i_tx_done = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL stray_tx_done: busy=%b start=%b, want 0/0", bus.o_busy, bus.o_tx_start);
        end
        do_seq(8'h01, 8'h01, 8'h20, 8'h02, "after_drop");
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        tx_count      = 0;
        rst           = 1'b1;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;
        test_reset();
        test_alu_ops();
        test_abort();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sits between the UART receiver and the UART transmitter inside top.
- Collects three received bytes in order: operand A, operand B, opcode. Computes the ALU result, then hands the result byte to the transmitter with a one-cycle start pulse.
- Provides the loopback/calculator path exercised end-to-end through i_data/o_result at top level.

Parameters:
- DBIT, 8, data/operand width in bits (UART frame payload)
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third received byte

Ports:
- i_clock  in  1  system clock (same clock as baud generator/UART)
- i_reset  in  1  synchronous, active-high reset
- i_rx_done  in  1  single-cycle pulse, i_rx_data valid this cycle
- i_rx_data  in  DBIT  received byte
- i_tx_done  in  1  single-cycle pulse from transmitter, frame finished
- o_tx_start  out  1  single-cycle pulse, transmitter loads o_tx_data
- o_tx_data  out  DBIT  result byte, held stable from o_tx_start until i_tx_done
- o_result  out  DBIT  last computed result, held until next compute
- o_busy  out  1  high in COMPUTE, SEND, WAIT_TX

Behaviour:
- Reset (sampled on rising i_clock while i_reset=1):
  - state=WAIT_A; A, B and OP registers = 0
  - o_tx_start=0, o_tx_data=0, o_result=0, o_busy=0
  - Reset wins over every other input in the same cycle and aborts any sequence in progress, including mid-SEND/WAIT_TX. No tx_start is issued after reset.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
  - WAIT_A: on i_rx_done, A<=i_rx_data, go to WAIT_B.
  - WAIT_B: on i_rx_done, B<=i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done, OP<=i_rx_data[NB_OP-1:0], go to COMPUTE.
  - COMPUTE (1 cycle): o_result<=alu(A,B,OP), o_tx_data<=same value, go to SEND.
  - SEND (1 cycle): o_tx_start=1, go to WAIT_TX.
  - WAIT_TX: o_tx_start=0; on i_tx_done, go to WAIT_A.
- Latency: opcode rx_done at cycle N → o_result valid at N+2, o_tx_start high at N+2 only.
- i_rx_done while in COMPUTE, SEND or WAIT_TX: byte dropped; it is not queued and not stored.
- i_rx_done and i_tx_done in the same cycle while in WAIT_TX: the byte is dropped, and the state moves to WAIT_A.
- i_tx_done outside WAIT_TX: ignored.
- i_rx_done while in a WAIT_x state is accepted regardless of the previous cycle; back-to-back pulses are legal.
- ALU, combinational, DBIT-wide result, all arithmetic modulo 2^DBIT:
  - ADD 6'b100000: A+B, carry discarded
  - SUB 6'b100010: A-B, two's complement wrap
  - AND 6'b100100: A&B
  - OR 6'b100101: A|B
  - XOR 6'b100110: A^B
  - NOR 6'b100111: ~(A|B)
  - SRA 6'b000011: A arithmetic right shift by B; B>=DBIT → all bits equal A[DBIT-1]
  - SRL 6'b000010: A logical right shift by B; B>=DBIT → 0
  - Any other opcode: result 0, still transmitted.
- Upper DBIT-NB_OP bits of the opcode byte are ignored.

Decomposition:
- Shared package/header holds:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL
  - state encoding constants (3-bit)
  - DBIT/NB_OP defaults
- One sub-module: alu (purely combinational, parameters DBIT, NB_OP; ports i_a, i_b, i_op, o_result). It is reused from the previous lab and instantiated once here.
- The FSM and operand registers live in uart_alu_interface.

Test Plan:
- rx 0x05, 0x03, 0x20 → exactly one o_tx_start pulse 2 cycles after third rx_done; o_tx_data=o_result=0x08; o_busy high until i_tx_done.
- rx 0x03, 0x05, 0x22 (SUB) → 0xFE. rx 0xFF, 0x01, 0x20 (ADD) → 0x00, wrap.
- rx 0x80, 0x02, 0x03 (SRA) → 0xE0. rx 0x80, 0x02, 0x02 (SRL) → 0x20. rx 0x80, 0x09, 0x03 → 0xFF.
- rx 0xAA, 0x55, 0x3F (unknown op) → o_tx_data=0x00, tx_start still pulses. rx 0xF0, 0x0F, 0xE7 (upper bits set, op NOR) → 0x00.
- rx 0x11 then assert i_reset 1 cycle, then rx 0x02, 0x03, 0x20 → result 0x05; no tx_start from the aborted sequence.
- After op byte, inject rx_done 0x77 during WAIT_TX, and separately one coincident with i_tx_done → both dropped. The next sequence 0x01, 0x01, 0x20 → 0x02.
